// File: rtl/memory_responder.sv
// Memory-side responder for the processor's address/data bus. It serves registered reads,
// accepts byte writes, and runs a host program-load engine that stalls the CPU while filling memory.
module memory_responder #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addbus,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] ramoutbus,
  output logic              cpu_hold,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(DEPTH - 1);

  // Handshake: a host byte transfers on every rising edge where load_valid && load_ready.
  // load_ready is high for the whole LOAD state, so one byte per cycle is sustained.
  typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic              xfer;
  logic              last_xfer;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign in_range  = ({1'b0, addbus} < DEPTH_LIM);
  assign xfer      = (state_q == S_LOAD) && load_valid;
  assign last_xfer = xfer && (load_last || (ptr_q == PTR_LAST));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_waddr = addbus[IDX_W-1:0];
    mem_wdata = wr_data;
    case (state_q)
      S_RUN: begin
        // Read uses the array before this edge's write: read-before-write on collision.
        if (rd_en) rdata_d = in_range ? mem[addbus[IDX_W-1:0]] : '0;
        mem_we = wr_en && in_range;
        if (load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_we    = 1'b1;
          mem_waddr = ptr_q;
          mem_wdata = load_data;
          count_d   = count_q + 1'b1;
          if (last_xfer) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      ptr_q   <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents are deliberately not reset, so a mid-load reset keeps loaded bytes.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign ramoutbus  = rdata_q;
  assign cpu_hold   = (state_q == S_LOAD);
  assign load_ready = (state_q == S_LOAD);
  assign load_done  = done_q;
  assign load_count = count_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a full-size instance driven from a vector table,
// plus a DEPTH=16 instance for the pointer-limit and out-of-range cases.
module tb_memory_responder;

  logic        clk;
  logic        rst_n;
  logic [14:0] addbus;
  logic        rd_en, wr_en;
  logic [7:0]  wr_data;
  logic        load_start, load_valid, load_last;
  logic [7:0]  load_data;

  logic [7:0]  ramoutbus, ramoutbus_s;
  logic        cpu_hold, cpu_hold_s;
  logic        load_ready, load_ready_s;
  logic        load_done, load_done_s;
  logic [15:0] load_count, load_count_s;

  int n_vec = 0;
  int n_err = 0;

  memory_responder dut (
    .clk(clk), .rst_n(rst_n), .addbus(addbus), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .ramoutbus(ramoutbus), .cpu_hold(cpu_hold),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .load_count(load_count)
  );

  memory_responder #(.DEPTH(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .addbus(addbus), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .ramoutbus(ramoutbus_s), .cpu_hold(cpu_hold_s),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_s), .load_done(load_done_s),
    .load_count(load_count_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [14:0] addr;
    logic [7:0]  wdata;
    logic        ls, lv;
    logic [7:0]  ld;
    logic        ll;
    logic [7:0]  e_ram;
    logic        e_hold, e_ready, e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [14:0] addr,
                              input logic [7:0] wdata, input logic ls, input logic lv,
                              input logic [7:0] ld, input logic ll, input logic [7:0] e_ram,
                              input logic e_hold, input logic e_ready, input logic e_done,
                              input logic [15:0] e_cnt);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ls = ls; v.lv = lv; v.ld = ld; v.ll = ll;
    v.e_ram = e_ram; v.e_hold = e_hold; v.e_ready = e_ready; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [14:0] addr,
                       input logic [7:0] wdata, input logic ls, input logic lv,
                       input logic [7:0] ld, input logic ll);
    @(negedge clk);
    rd_en = rd; wr_en = wr; addbus = addr; wr_data = wdata;
    load_start = ls; load_valid = lv; load_data = ld; load_last = ll;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v.rd, v.wr, v.addr, v.wdata, v.ls, v.lv, v.ld, v.ll);
    step();
    chk($sformatf("v%0d ramoutbus", idx), {24'd0, ramoutbus}, {24'd0, v.e_ram});
    chk($sformatf("v%0d cpu_hold", idx), {31'd0, cpu_hold}, {31'd0, v.e_hold});
    chk($sformatf("v%0d load_ready", idx), {31'd0, load_ready}, {31'd0, v.e_ready});
    chk($sformatf("v%0d load_done", idx), {31'd0, load_done}, {31'd0, v.e_done});
    chk($sformatf("v%0d load_count", idx), {16'd0, load_count}, {16'd0, v.e_cnt});
  endtask

  initial begin
    int s_done_pulses;

    rst_n = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; addbus = '0; wr_data = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;

    // ---- table: rd wr addr wdata | ls lv ld ll | ram hold ready done count
    // load 4 bytes after one idle LOAD cycle -> 5 cycles of hold
    vt.push_back(mk(0,0,15'h0000,8'h00, 1,0,8'h00,0, 8'h00,1,1,0,16'd0));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h00,1,1,0,16'd0));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h3A,0, 8'h00,1,1,0,16'd1));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h10,0, 8'h00,1,1,0,16'd2));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'hFF,0, 8'h00,1,1,0,16'd3));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h07,1, 8'h00,0,0,1,16'd4));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h00,0,0,0,16'd4));
    vt.push_back(mk(1,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h3A,0,0,0,16'd4));
    vt.push_back(mk(1,0,15'h0001,8'h00, 0,0,8'h00,0, 8'h10,0,0,0,16'd4));
    vt.push_back(mk(1,0,15'h0002,8'h00, 0,0,8'h00,0, 8'hFF,0,0,0,16'd4));
    vt.push_back(mk(1,0,15'h0003,8'h00, 0,0,8'h00,0, 8'h07,0,0,0,16'd4));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h07,0,0,0,16'd4));
    // load with gaps: valid 1,0,0,1,1(last)
    vt.push_back(mk(0,0,15'h0000,8'h00, 1,0,8'h00,0, 8'h07,1,1,0,16'd0));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h21,0, 8'h07,1,1,0,16'd1));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,0,8'hEE,0, 8'h07,1,1,0,16'd1));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,0,8'hEE,1, 8'h07,1,1,0,16'd1));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h22,0, 8'h07,1,1,0,16'd2));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h23,1, 8'h07,0,0,1,16'd3));
    vt.push_back(mk(1,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h21,0,0,0,16'd3));
    vt.push_back(mk(1,0,15'h0001,8'h00, 0,0,8'h00,0, 8'h22,0,0,0,16'd3));
    vt.push_back(mk(1,0,15'h0002,8'h00, 0,0,8'h00,0, 8'h23,0,0,0,16'd3));
    vt.push_back(mk(1,0,15'h0003,8'h00, 0,0,8'h00,0, 8'h07,0,0,0,16'd3));
    // RUN write/read and read-before-write collision
    vt.push_back(mk(0,1,15'h1234,8'h5C, 0,0,8'h00,0, 8'h07,0,0,0,16'd3));
    vt.push_back(mk(1,0,15'h1234,8'h00, 0,0,8'h00,0, 8'h5C,0,0,0,16'd3));
    vt.push_back(mk(1,1,15'h1234,8'h99, 0,0,8'h00,0, 8'h5C,0,0,0,16'd3));
    vt.push_back(mk(1,0,15'h1234,8'h00, 0,0,8'h00,0, 8'h99,0,0,0,16'd3));
    vt.push_back(mk(0,1,15'h0005,8'h42, 0,0,8'h00,0, 8'h99,0,0,0,16'd3));
    // CPU access ignored during LOAD
    vt.push_back(mk(0,0,15'h0000,8'h00, 1,0,8'h00,0, 8'h99,1,1,0,16'd0));
    vt.push_back(mk(1,1,15'h0005,8'hAA, 0,0,8'h00,0, 8'h99,1,1,0,16'd0));
    vt.push_back(mk(1,0,15'h0005,8'h00, 1,0,8'h00,0, 8'h99,1,1,0,16'd0));
    vt.push_back(mk(0,0,15'h0000,8'h00, 0,1,8'h11,1, 8'h99,0,0,1,16'd1));
    vt.push_back(mk(1,0,15'h0005,8'h00, 0,0,8'h00,0, 8'h42,0,0,0,16'd1));
    vt.push_back(mk(1,0,15'h0000,8'h00, 0,0,8'h00,0, 8'h11,0,0,0,16'd1));

    repeat (2) @(posedge clk);
    #1;
    chk("reset ramoutbus", {24'd0, ramoutbus}, 32'd0);
    chk("reset cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("reset load_ready", {31'd0, load_ready}, 32'd0);
    chk("reset load_done", {31'd0, load_done}, 32'd0);
    chk("reset load_count", {16'd0, load_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // ---- DEPTH=16 instance: 20 bytes offered without load_last
    drive(0,0,15'h0,8'h0, 1,0,8'h0,0);
    step();
    s_done_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0,0,15'h0,8'h0, 0,1,8'h80 + 8'(i),0);
      step();
      if (load_done_s) s_done_pulses++;
      if (i < 15) chk($sformatf("small ready byte%0d", i), {31'd0, load_ready_s}, 32'd1);
      if (i == 15) begin
        chk("small done after 16", {31'd0, load_done_s}, 32'd1);
        chk("small ready after 16", {31'd0, load_ready_s}, 32'd0);
        chk("small hold after 16", {31'd0, cpu_hold_s}, 32'd0);
      end
    end
    drive(0,0,15'h0,8'h0, 0,0,8'h0,0);
    step();
    chk("small done pulses", s_done_pulses, 32'd1);
    chk("small load_count", {16'd0, load_count_s}, 32'd16);
    chk("big load_count 20", {16'd0, load_count}, 32'd20);
    chk("big still loading", {31'd0, load_ready}, 32'd1);
    drive(1,0,15'd20,8'h0, 0,0,8'h0,0);
    step();
    chk("small rd addr20", {24'd0, ramoutbus_s}, 32'd0);
    drive(0,1,15'd20,8'h55, 0,0,8'h0,0);
    step();
    drive(1,0,15'd4,8'h0, 0,0,8'h0,0);
    step();
    chk("small rd addr4", {24'd0, ramoutbus_s}, 32'h84);
    drive(1,0,15'd20,8'h0, 0,0,8'h0,0);
    step();
    chk("small rd addr20 after wr", {24'd0, ramoutbus_s}, 32'd0);
    drive(1,0,15'd15,8'h0, 0,0,8'h0,0);
    step();
    chk("small rd addr15", {24'd0, ramoutbus_s}, 32'h8F);

    // ---- reset in the middle of a load
    drive(0,0,15'h0,8'h0, 0,0,8'h0,0);
    rst_n = 1'b0;
    #1;
    chk("rst from load hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst from load ramoutbus", {24'd0, ramoutbus}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0,0,15'h0,8'h0, 1,0,8'h0,0);
    step();
    drive(0,0,15'h0,8'h0, 0,1,8'h61,0);
    step();
    drive(0,0,15'h0,8'h0, 0,1,8'h62,0);
    step();
    chk("mid-load count 2", {16'd0, load_count}, 32'd2);
    drive(0,0,15'h0,8'h0, 0,1,8'h63,0);
    rst_n = 1'b0;
    #1;
    chk("mid-rst cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("mid-rst load_ready", {31'd0, load_ready}, 32'd0);
    chk("mid-rst load_count", {16'd0, load_count}, 32'd0);
    chk("mid-rst load_done", {31'd0, load_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post-rst no done %0d", i), {31'd0, load_done}, 32'd0);
      chk($sformatf("post-rst hold %0d", i), {31'd0, cpu_hold}, 32'd0);
    end
    drive(1,0,15'd0,8'h0, 0,0,8'h0,0);
    step();
    chk("post-rst rd addr0", {24'd0, ramoutbus}, 32'h61);
    drive(1,0,15'd1,8'h0, 0,0,8'h0,0);
    step();
    chk("post-rst rd addr1", {24'd0, ramoutbus}, 32'h62);
    drive(1,0,15'd2,8'h0, 0,0,8'h0,0);
    step();
    chk("post-rst rd addr2", {24'd0, ramoutbus}, 32'h82);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the processor's 15-bit address / 8-bit data bus.
- Serves instruction and operand reads through a registered RAMOUTBUS.
- Accepts byte writes from the processor, e.g. the low byte of ACOUT on a store.
- Includes a host program-load engine that fills memory sequentially over a valid/ready handshake while holding the processor.

Parameters:
- ADDR_W, 15, address width; matches ADDBUS.
- DATA_W, 8, data width; matches RAMOUTBUS.
- DEPTH, 32768, implemented words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- addbus  in  ADDR_W  processor address (ADDBUS).
- rd_en  in  1  processor read strobe.
- wr_en  in  1  processor write strobe.
- wr_data  in  DATA_W  processor write data.
- ramoutbus  out  DATA_W  registered read data to the processor (RAMOUTBUS).
- cpu_hold  out  1  high while loading; the processor must stall.
- load_start  in  1  one-cycle pulse; begins a program load at address 0.
- load_valid  in  1  host byte valid.
- load_data  in  DATA_W  host byte.
- load_last  in  1  qualifies the final byte, sampled with load_valid.
- load_ready  out  1  responder can accept a host byte.
- load_done  out  1  one-cycle pulse when a load completes.
- load_count  out  ADDR_W+1  bytes written by the current or most recent load.

Behaviour:
- Array: DEPTH x DATA_W; contents are not reset.
- Reset (async, rst_n=0):
  - state=RUN, ramoutbus=0, cpu_hold=0, load_ready=0, load_done=0, load_count=0, load pointer=0.
- States: RUN and LOAD.
- RUN:
  - Read: rd_en=1 at edge N → ramoutbus = mem[addbus] after edge N+1 (1-cycle latency). ramoutbus holds its value when rd_en=0.
  - Write: wr_en=1 at an edge → mem[addbus] = wr_data.
  - rd_en and wr_en together at the same address: read-before-write. ramoutbus gets the old contents; the new value is visible to the next read.
  - Address ≥ DEPTH: reads return 0; writes are ignored.
  - load_start=1 → LOAD next cycle. Pointer=0, load_count=0, cpu_hold=1, load_ready=1.
- LOAD:
  - rd_en and wr_en are ignored; ramoutbus holds its last value.
  - A transfer happens when load_valid && load_ready at an edge: mem[ptr]=load_data, ptr+1, load_count+1.
  - load_ready stays high through consecutive transfers (one byte per cycle sustained). Host may drop load_valid at any time with no effect.
  - Transfer with load_last=1, or transfer at ptr=DEPTH-1: that byte is written, then next cycle state=RUN, cpu_hold=0, load_ready=0, load_done=1 for exactly 1 cycle.
  - Pointer never wraps; transfers beyond DEPTH are impossible because load_ready is already low.
  - load_start during LOAD is ignored.
- load_count: holds its final value until the next load_start.
- Reset mid-load:
  - Returns immediately to RUN with all reset values.
  - Bytes already written stay in memory.
  - No load_done pulse.
- cpu_hold: asserted the cycle after load_start; deasserted the cycle load_done is high.

Test Plan:
1. Reset, then load_start, then 4 bytes 0x3A,0x10,0xFF,0x07 back-to-back with load_last on the 4th → load_done pulses once; load_count=4; cpu_hold high for 5 cycles. Reads of addresses 0..3 then return 0x3A,0x10,0xFF,0x07, each 1 cycle after rd_en.
2. Load with gaps: load_valid toggling 1,0,0,1,1(last) → exactly 3 bytes written at addresses 0..2; load_count=3; no write on invalid cycles.
3. RUN write/read: wr_en at 0x1234 with 0x5C, then rd_en at 0x1234 → ramoutbus=0x5C one cycle later. Simultaneous rd_en+wr_en at 0x1234 with 0x99 → ramoutbus=0x5C; next read returns 0x99.
4. DEPTH=16, load 20 bytes with no load_last → 16 bytes accepted; load_ready low after byte 16; load_done fires; load_count=16. Read at address 20 returns 0; write at address 20 is ignored.
5. Assert rst_n=0 after 2 of 5 load bytes → state RUN, cpu_hold=0, load_count=0, no load_done. Addresses 0..1 hold the loaded bytes.
6. During LOAD, drive rd_en/wr_en at address 0x0005 → memory is unchanged at 0x0005 and ramoutbus holds its last value.
